// File: rtl/rca_multiword_add_seq.sv
// Multi-word add sequencer: feeds one 32-bit ripple-carry adder a word per cycle, LS word first.
// Optional subtract support is enabled by defining RCA_SEQ_SUB_EN (adds the op_sub port).

module rca32_adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c0_i,
    output logic [31:0] s_o,
    output logic        cout_o
);
    logic [32:0] c_s;

    assign c_s[0] = c0_i;
    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign s_o[i]     = a_i[i] ^ b_i[i] ^ c_s[i];
        assign c_s[i + 1] = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
    end
    assign cout_o = c_s[32];
endmodule

module rca_multiword_add_seq #(
    parameter  int NUM_WORDS = 4,
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int W         = NUM_WORDS * 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic          op_sub,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic          out_cout,
    output logic          out_ovf,
    output logic          busy,
    output logic [31:0]   add_a,
    output logic [31:0]   add_b,
    output logic          add_c0,
    input  logic [31:0]   add_s,
    input  logic          add_cout
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             sub_s;
    logic             in_ready_s;

`ifdef RCA_SEQ_SUB_EN
    assign sub_s = op_sub;
`else
    assign sub_s = 1'b0;
`endif

    assign in_ready_s = (state_q == ST_IDLE) && rst_n;

    // State and datapath registers; synchronous active-low reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic and adder drive; the adder sees zeros whenever no word is in flight
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        add_a   = 32'd0;
        add_b   = 32'd0;
        add_c0  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_s) begin
                    a_d     = in_a;
                    b_d     = sub_s ? ~in_b : in_b;
                    carry_d = sub_s ? 1'b1 : in_cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                add_a   = a_q[{idx_q, 5'd0} +: 32];
                add_b   = b_q[{idx_q, 5'd0} +: 32];
                add_c0  = carry_q;
                sum_d[{idx_q, 5'd0} +: 32] = add_s;
                carry_d = add_cout;
                if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                    // Overflow uses the effective (possibly inverted) B sign bit
                    cout_d  = add_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[31] != a_q[W-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_rca_multiword_add_seq.sv
// Directed self-checking bench for rca_multiword_add_seq (NUM_WORDS=4, W=128).
// The subtract scenario is compiled in only when RCA_SEQ_SUB_EN is defined.

module tb_rca_multiword_add_seq;
    localparam int NW = 4;
    localparam int W  = NW * 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
`ifdef RCA_SEQ_SUB_EN
    logic          op_sub;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          busy;
    logic [31:0]   add_a;
    logic [31:0]   add_b;
    logic          add_c0;
    logic [31:0]   add_s;
    logic          add_cout;

    int total;
    int bad;

    rca_multiword_add_seq #(.NUM_WORDS(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef RCA_SEQ_SUB_EN
        .op_sub(op_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
        .add_s(add_s), .add_cout(add_cout)
    );

    rca32_adder u_adder (
        .a_i(add_a), .b_i(add_b), .c0_i(add_c0), .s_o(add_s), .cout_o(add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake in the current cycle, then scramble the inputs
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        in_cin   = ~cin;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_low got=%b exp=0", in_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_after got=%b exp=1", in_ready); end
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_valid_busy got=%b%b exp=00", out_valid, busy);
        end
        total++;
        if (out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL rst_outputs got=%h/%b/%b exp=0/0/0", out_sum, out_cout, out_ovf);
        end
        total++;
        if (add_a !== 32'd0 || add_b !== 32'd0 || add_c0 !== 1'b0) begin
            bad++; $display("FAIL rst_adder_idle got=%h/%h/%b exp=0/0/0", add_a, add_b, add_c0);
        end
    endtask

    task automatic test_wrap_latency();
        int n;
        issue({W{1'b1}}, 128'd1, 1'b0);
        wait_done(n);
        total++;
        if (n != NW) begin bad++; $display("FAIL t1_latency got=%0d exp=%0d", n, NW); end
        total++;
        if (out_sum !== 128'd0) begin bad++; $display("FAIL t1_sum got=%h exp=0", out_sum); end
        total++;
        if (out_cout !== 1'b1 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL t1_cout_ovf got=%b%b exp=10", out_cout, out_ovf);
        end
        tick();
    endtask

    task automatic test_signed_ovf();
        logic [W-1:0] a;
        logic [3:0]   c0_exp;
        a      = {1'b0, {(W-1){1'b1}}};
        c0_exp = 4'b1110;
        issue(a, 128'd1, 1'b0);
        for (int w = 0; w < NW; w++) begin
            total++;
            if (add_c0 !== c0_exp[w] || add_a !== a[w*32 +: 32]) begin
                bad++; $display("FAIL t2_word%0d got=%b/%h exp=%b/%h", w, add_c0, add_a, c0_exp[w], a[w*32 +: 32]);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b1 || out_sum !== {1'b1, {(W-1){1'b0}}}) begin
            bad++; $display("FAIL t2_sum got=%b/%h exp=1/%h", out_valid, out_sum, {1'b1, {(W-1){1'b0}}});
        end
        total++;
        if (out_cout !== 1'b0 || out_ovf !== 1'b1) begin
            bad++; $display("FAIL t2_cout_ovf got=%b%b exp=01", out_cout, out_ovf);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        logic [W-1:0] exp_sum;
        exp_sum   = 128'h0000_0011_0000_0022_0000_0033_0000_0045;
        out_ready = 1'b0;
        issue(128'h0000_0001_0000_0002_0000_0003_0000_0004,
              128'h0000_0010_0000_0020_0000_0030_0000_0040, 1'b1);
        wait_done(n);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== exp_sum || out_cout !== 1'b0) begin
                bad++; $display("FAIL t3_hold%0d got=%b%b/%h/%b exp=10/%h/0", i, out_valid, in_ready, out_sum, out_cout, exp_sum);
            end
            in_valid = i[0];
            in_a     = 128'd99;
            in_b     = 128'd1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL t3_release got=%b%b%b exp=010", out_valid, in_ready, busy);
        end
        total++;
        if (out_sum !== exp_sum) begin bad++; $display("FAIL t3_sum_hold got=%h exp=%h", out_sum, exp_sum); end
    endtask

    task automatic test_abort();
        int n;
        int seen;
        issue(128'h4444_4444_3333_3333_2222_2222_1111_1111, 128'd0, 1'b0);
        tick();
        tick();
        total++;
        if (add_a !== 32'h3333_3333) begin bad++; $display("FAIL t4_idx2 got=%h exp=33333333", add_a); end
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL t4_ready_in_rst got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0) begin
            bad++; $display("FAIL t4_after_rst got=%b%b/%h exp=10/0", in_ready, out_valid, out_sum);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL t4_no_valid got=%0d exp=0", seen); end
        issue(128'd3, 128'd4, 1'b0);
        wait_done(n);
        total++;
        if (n != NW || out_sum !== 128'd7) begin bad++; $display("FAIL t4_sum got=%0d/%h exp=%0d/7", n, out_sum, NW); end
        tick();
    endtask

`ifdef RCA_SEQ_SUB_EN
    task automatic test_sub();
        int n;
        op_sub = 1'b1;
        issue(128'd5, 128'd7, 1'b0);
        wait_done(n);
        total++;
        if (out_sum !== {{(W-1){1'b1}}, 1'b0} || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL t5_5m7 got=%h/%b%b exp=%h/00", out_sum, out_cout, out_ovf, {{(W-1){1'b1}}, 1'b0});
        end
        tick();
        issue(128'd7, 128'd5, 1'b1);
        wait_done(n);
        total++;
        if (out_sum !== 128'd2 || out_cout !== 1'b1 || out_ovf !== 1'b0) begin
            bad++; $display("FAIL t5_7m5 got=%h/%b%b exp=2/10", out_sum, out_cout, out_ovf);
        end
        tick();
        op_sub = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic         vc [3];
        logic [W-1:0] es [3];
        logic         ec [3];
        int sent, rcv, cyc, last;
        logic hs;
        va[0] = 128'd10;                       vb[0] = 128'd20;        vc[0] = 1'b1;
        va[1] = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
        vb[1] = 128'd1;                        vc[1] = 1'b0;
        va[2] = {W{1'b1}};                     vb[2] = {W{1'b1}};      vc[2] = 1'b1;
        es[0] = 128'd31;                       ec[0] = 1'b0;
        es[1] = 128'h0000_0000_0000_0001_0000_0000_0000_0000;       ec[1] = 1'b0;
        es[2] = {W{1'b1}};                     ec[2] = 1'b1;
        sent = 0; rcv = 0; cyc = 0; last = 0;
        out_ready = 1'b1;
        in_a = va[0]; in_b = vb[0]; in_cin = vc[0]; in_valid = 1'b1;
        while (rcv < 3 && cyc < 60) begin
            if (out_valid === 1'b1) begin
                total++;
                if (out_sum !== es[rcv] || out_cout !== ec[rcv]) begin
                    bad++; $display("FAIL t6_res%0d got=%h/%b exp=%h/%b", rcv, out_sum, out_cout, es[rcv], ec[rcv]);
                end
                rcv++;
            end
            hs = in_valid && in_ready;
            tick();
            cyc++;
            if (hs) begin
                if (sent > 0) begin
                    total++;
                    if (cyc - last != NW + 2) begin bad++; $display("FAIL t6_interval got=%0d exp=%0d", cyc - last, NW + 2); end
                end
                last = cyc;
                sent++;
                if (sent < 3) begin
                    in_a = va[sent]; in_b = vb[sent]; in_cin = vc[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (rcv != 3) begin bad++; $display("FAIL t6_count got=%0d exp=3", rcv); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
`ifdef RCA_SEQ_SUB_EN
        op_sub = 1'b0;
`endif
        test_reset();
        test_wrap_latency();
        test_signed_ovf();
        test_backpressure();
        test_abort();
`ifdef RCA_SEQ_SUB_EN
        test_sub();
`endif
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
